cheat_engine_multi: RTL and testbench
=====================================

// Module: cheat_engine_multi
// PURPOSE
//  Parametrised ROM-patch and vector-hook engine on the SNES bus. NUM_SLOTS address/data patch slots
//  override the ROM data; NMI/IRQ vector hooks redirect into the snescmd handler. Adds saturating
//  per-slot hit counters (MCU readback), configurable usage window, holdoff and sync depth. Sits beside
//  the ROM mux: data_out replaces ROM data whenever cheat_hit is 1.
// PARAMETERS
//  NUM_SLOTS      8          patch slots, 1..32
//  IDXW           clog2(NUM_SLOTS+2)  pgm_idx/rd_idx width (derived, localparam)
//  HOLDOFF_CYCLES 880000000  hook-disable time after arm event, clk cycles; counter 30 bits
//  USAGE_WIN_LOG2 21         auto-select window = 2**USAGE_WIN_LOG2 clk cycles
//  SYNC_CYCLES    2          quiet bus cycles required before hook state may change
//  HITW           16         per-slot hit counter width
// PORTS
//  clk               in  1     system clock
//  rst_n             in  1     async active-low reset
//  SNES_ADDR         in  24    SNES bus address
//  SNES_DATA         in  8     SNES bus data (snescmd writes)
//  SNES_reset_strobe in  1     1-clk pulse on SNES reset release
//  snescmd_wr_strobe in  1     1-clk pulse, write into snescmd area
//  SNES_cycle_start  in  1     1-clk pulse at start of each SNES bus cycle
//  pgm_idx           in  IDXW  MCU program index
//  pgm_we            in  1     MCU program strobe
//  pgm_in            in  32    MCU program data
//  rd_idx            in  IDXW  hit counter select (slot number)
//  rd_data           out HITW  hit count of slot rd_idx (0 if rd_idx>=NUM_SLOTS); registered, 1 clk
//  data_out          out 8     replacement byte (combinational)
//  cheat_hit         out 1     override ROM data (combinational)
// BEHAVIOUR
//  Reset: all slot addr/data/counters 0, enable mask 0, cheat/nmi/irq/holdoff enables 0, hook_disable 0,
//   auto_nmi 1, auto_irq 0, *_sync 0, sync counter SYNC_CYCLES, holdoff counter 0, window counter
//   all-ones, usage counters 0, rd_data 0. Outputs: data_out 8'h2b, cheat_hit 0.
//  Slot match i = mask[i] & (SNES_ADDR==addr[i]). Lowest matching index wins data_out; else
//   00FFEA/00FFEB -> e0/2b, 00FFEE/00FFEF -> e6/2b, else 2b.
//  cheat_hit = (cheat_enable & any slot match) | hook_en_sync & ((auto_nmi_sync&nmi_enable&nmi_vec)
//   | (auto_irq_sync&irq_enable&irq_vec)).
//  Program map (pgm_we): idx<NUM_SLOTS: addr<=pgm_in[31:8], data<=pgm_in[7:0], that slot counter<=0;
//   idx==NUM_SLOTS: mask<=pgm_in[NUM_SLOTS-1:0]; idx==NUM_SLOTS+1: {holdoff,irq,nmi,cheat} <=
//   (cur & ~pgm_in[7:4]) | pgm_in[3:0]; other idx ignored. snescmd_wr_strobe has priority over pgm_we.
//  snescmd at ADDR[8:0]==0: 82 cheat_enable<=1; 83 <=0; 84 nmi/irq_enable<=0; 85 arm holdoff;
//   86 clear all hit counters. ADDR[8:0]==1fd: hook_disable<=SNES_DATA[0].
//  Holdoff: load HOLDOFF_CYCLES on cmd 85 or (holdoff_enable & SNES_reset_strobe), else decrement to 0.
//   hook_enable = (count==0) & ~hook_disable.
//  Hit counters: on SNES_cycle_start & cheat_enable & match i (winner only), counter i += 1, saturates at
//   all-ones. Slot-program or cmd 86 in same clk wins (counter=0).
//  Auto-select (window FSM COUNT->EVAL): COUNT: on SNES_cycle_start & ~hook_disable, low-byte vector read
//   (FFEB/FFEF) increments nmi/irq usage, 5-bit saturating. EVAL (window counter==0, 1 clk): both
//   nonzero or irq==0 -> nmi mode; else nmi==0 -> irq mode; usage reset to 0 then back to COUNT.
//  Sync: on SNES_cycle_start: vector address (any of 4) reloads sync counter to SYNC_CYCLES; else
//   decrement; when already 0, copy auto_nmi/auto_irq/hook_enable into *_sync. Never change mid-vector.
//  rst_n asserted mid-operation: immediate return to reset state, incl. holdoff count and counters.
// TESTING
//  Slot 3 addr 008000 data 5a, mask 08, cmd 82; read 008000 -> cheat_hit 1, data_out 5a; cmd 83 -> hit 0.
//  Slots 1,4 both 00c000 (data 11/44), mask 12 -> data_out 11; only counter 1 increments.
//  255 cycle_start hits with HITW=8 -> rd_data ff, stays ff; cmd 86 -> rd_data 0 next clk.
//  nmi_enable set, 3 reads FFEA/FFEB per window, no IRQ -> after window + 2 quiet cycles, FFEB -> e0 hit.
//  cmd 85 with HOLDOFF_CYCLES=100 -> no hook hit for 100 clk + sync; 1fd=1 -> hooks off immediately.
//  rst_n low mid-window with slots programmed -> cheat_hit 0, data_out 2b, rd_data 0 asynchronously.

Source files
------------

// File: rtl/cheat_engine_multi.sv
// cheat_engine_multi: ROM patch slots and NMI/IRQ vector hooks sitting beside the SNES ROM mux.
// Slot hit counters are MCU-readable; hook mode is auto-selected from vector usage per window.
module cheat_engine_multi #(
   parameter  int NUM_SLOTS      = 8,
   parameter  int HOLDOFF_CYCLES = 880000000,
   parameter  int USAGE_WIN_LOG2 = 21,
   parameter  int SYNC_CYCLES    = 2,
   parameter  int HITW           = 16,
   localparam int IDXW           = $clog2(NUM_SLOTS+2)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [23:0]     SNES_ADDR,
   input  logic [7:0]      SNES_DATA,
   input  logic            SNES_reset_strobe,
   input  logic            snescmd_wr_strobe,
   input  logic            SNES_cycle_start,
   input  logic [IDXW-1:0] pgm_idx,
   input  logic            pgm_we,
   input  logic [31:0]     pgm_in,
   input  logic [IDXW-1:0] rd_idx,
   output logic [HITW-1:0] rd_data,
   output logic [7:0]      data_out,
   output logic            cheat_hit
);

   localparam int                      SCW          = $clog2(SYNC_CYCLES+2);
   localparam logic [SCW-1:0]          SYNC_LOAD    = SCW'(SYNC_CYCLES);
   localparam logic [29:0]             HOLDOFF_LOAD = 30'(HOLDOFF_CYCLES);
   localparam logic [USAGE_WIN_LOG2-1:0] WIN_ONE    = USAGE_WIN_LOG2'(1);

   // state   | meaning
   // ST_COUNT | accumulating vector usage over the window
   // ST_EVAL  | window counter at 0: pick hook mode, clear usage
   typedef enum logic {ST_COUNT, ST_EVAL} win_state_t;

   win_state_t r_state, w_state_nxt;
   logic       w_eval, w_count;

   logic [23:0]          r_addr [NUM_SLOTS];
   logic [7:0]           r_data [NUM_SLOTS];
   logic [HITW-1:0]      r_cnt  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_mask;
   logic                 r_cheat_en, r_nmi_en, r_irq_en, r_holdoff_en, r_hook_disable;
   logic                 r_auto_nmi, r_auto_irq;
   logic                 r_auto_nmi_sync, r_auto_irq_sync, r_hook_en_sync;
   logic [SCW-1:0]       r_sync_cnt;
   logic [29:0]          r_holdoff_cnt;
   logic [USAGE_WIN_LOG2-1:0] r_win_cnt;
   logic [4:0]           r_nmi_use, r_irq_use;
   logic [HITW-1:0]      r_rd_data;

   logic [NUM_SLOTS-1:0] w_match, w_win_oh, w_pgm_slot;
   logic                 w_any_match;
   logic [7:0]           w_slot_data;
   logic [HITW-1:0]      w_rd_sel;
   logic w_nmi_lo, w_nmi_hi, w_irq_lo, w_irq_hi, w_nmi_vec, w_irq_vec, w_any_vec;
   logic w_cmd_lo, w_cmd_82, w_cmd_83, w_cmd_84, w_cmd_85, w_cmd_86, w_cmd_1fd;
   logic w_pgm, w_pgm_mask, w_pgm_ctl, w_hook_en, w_cnt_inc;

   assign w_nmi_lo  = (SNES_ADDR == 24'h00ffea);
   assign w_nmi_hi  = (SNES_ADDR == 24'h00ffeb);
   assign w_irq_lo  = (SNES_ADDR == 24'h00ffee);
   assign w_irq_hi  = (SNES_ADDR == 24'h00ffef);
   assign w_nmi_vec = w_nmi_lo | w_nmi_hi;
   assign w_irq_vec = w_irq_lo | w_irq_hi;
   assign w_any_vec = w_nmi_vec | w_irq_vec;

   assign w_cmd_lo  = snescmd_wr_strobe & (SNES_ADDR[8:0] == 9'h000);
   assign w_cmd_82  = w_cmd_lo & (SNES_DATA == 8'h82);
   assign w_cmd_83  = w_cmd_lo & (SNES_DATA == 8'h83);
   assign w_cmd_84  = w_cmd_lo & (SNES_DATA == 8'h84);
   assign w_cmd_85  = w_cmd_lo & (SNES_DATA == 8'h85);
   assign w_cmd_86  = w_cmd_lo & (SNES_DATA == 8'h86);
   assign w_cmd_1fd = snescmd_wr_strobe & (SNES_ADDR[8:0] == 9'h1fd);

   // a snescmd write in the same clk blocks the MCU program write entirely
   assign w_pgm      = pgm_we & ~snescmd_wr_strobe;
   assign w_pgm_mask = w_pgm & (pgm_idx == IDXW'(NUM_SLOTS));
   assign w_pgm_ctl  = w_pgm & (pgm_idx == IDXW'(NUM_SLOTS + 1));

   always_comb begin
      w_match     = '0;
      w_win_oh    = '0;
      w_pgm_slot  = '0;
      w_any_match = 1'b0;
      w_slot_data = 8'h00;
      w_rd_sel    = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         w_match[i]    = r_mask[i] & (SNES_ADDR == r_addr[i]);
         w_pgm_slot[i] = w_pgm & (pgm_idx == IDXW'(i));
         if (rd_idx == IDXW'(i)) w_rd_sel = r_cnt[i];
         if (w_match[i]) begin
            w_any_match = 1'b1;
            w_slot_data = r_data[i];
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      data_out = 8'h2b;
      if (w_any_match)                data_out = w_slot_data;
      else if (w_nmi_lo)              data_out = 8'he0;
      else if (w_irq_lo)              data_out = 8'he6;
   end

   assign cheat_hit = (r_cheat_en & w_any_match) |
                      (r_hook_en_sync & ((r_auto_nmi_sync & r_nmi_en & w_nmi_vec) |
                                         (r_auto_irq_sync & r_irq_en & w_irq_vec)));
   assign rd_data   = r_rd_data;
   assign w_hook_en = (r_holdoff_cnt == '0) & ~r_hook_disable;
   assign w_cnt_inc = SNES_cycle_start & r_cheat_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_pgm_slot[i]) begin
               r_addr[i] <= pgm_in[31:8];
               r_data[i] <= pgm_in[7:0];
            end
            if (w_pgm_slot[i] | w_cmd_86)
               r_cnt[i] <= '0;
            else if (w_cnt_inc & w_win_oh[i] & ~&r_cnt[i])
               r_cnt[i] <= r_cnt[i] + HITW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask         <= '0;
         r_cheat_en     <= 1'b0;
         r_nmi_en       <= 1'b0;
         r_irq_en       <= 1'b0;
         r_holdoff_en   <= 1'b0;
         r_hook_disable <= 1'b0;
         r_rd_data      <= '0;
         r_holdoff_cnt  <= '0;
      end else begin
         if (w_pgm_mask) r_mask <= pgm_in[NUM_SLOTS-1:0];
         if (w_pgm_ctl)
            {r_holdoff_en, r_irq_en, r_nmi_en, r_cheat_en} <=
               ({r_holdoff_en, r_irq_en, r_nmi_en, r_cheat_en} & ~pgm_in[7:4]) | pgm_in[3:0];
         if (w_cmd_82) r_cheat_en <= 1'b1;
         if (w_cmd_83) r_cheat_en <= 1'b0;
         if (w_cmd_84) begin
            r_nmi_en <= 1'b0;
            r_irq_en <= 1'b0;
         end
         if (w_cmd_1fd) r_hook_disable <= SNES_DATA[0];
         r_rd_data <= w_rd_sel;
         if (w_cmd_85 | (r_holdoff_en & SNES_reset_strobe))
            r_holdoff_cnt <= HOLDOFF_LOAD;
         else if (r_holdoff_cnt != '0)
            r_holdoff_cnt <= r_holdoff_cnt - 30'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_COUNT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_COUNT: if (r_win_cnt == WIN_ONE) w_state_nxt = ST_EVAL;
         ST_EVAL:  w_state_nxt = ST_COUNT;
         default:  w_state_nxt = ST_COUNT;
      endcase
   end

   always_comb begin
      w_eval  = (r_state == ST_EVAL);
      w_count = (r_state == ST_COUNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_cnt  <= '1;
         r_nmi_use  <= '0;
         r_irq_use  <= '0;
         r_auto_nmi <= 1'b1;
         r_auto_irq <= 1'b0;
      end else begin
         r_win_cnt <= r_win_cnt - WIN_ONE;
         if (w_eval) begin
            r_nmi_use <= '0;
            r_irq_use <= '0;
            // an idle window falls back to NMI mode
            if ((r_nmi_use != '0 && r_irq_use != '0) || r_irq_use == '0)
               {r_auto_nmi, r_auto_irq} <= 2'b10;
            else
               {r_auto_nmi, r_auto_irq} <= 2'b01;
         end else if (w_count & SNES_cycle_start & ~r_hook_disable) begin
            if (w_nmi_hi & ~&r_nmi_use) r_nmi_use <= r_nmi_use + 5'd1;
            if (w_irq_hi & ~&r_irq_use) r_irq_use <= r_irq_use + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_cnt      <= SYNC_LOAD;
         r_auto_nmi_sync <= 1'b0;
         r_auto_irq_sync <= 1'b0;
         r_hook_en_sync  <= 1'b0;
      end else if (SNES_cycle_start) begin
         if (w_any_vec)
            r_sync_cnt <= SYNC_LOAD;
         else if (r_sync_cnt != '0)
            r_sync_cnt <= r_sync_cnt - SCW'(1);
         else begin
            r_auto_nmi_sync <= r_auto_nmi;
            r_auto_irq_sync <= r_auto_irq;
            r_hook_en_sync  <= w_hook_en;
         end
      end
   end

endmodule

// File: tb/tb_cheat_engine_multi.sv
// Bench for cheat_engine_multi: random slot traffic against a lookup model, plus directed
// hook-mode, holdoff, disable and async reset scenarios.
module tb_cheat_engine_multi;
   localparam int NS = 8;
   localparam int IW = 4;
   localparam int HW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [23:0]   SNES_ADDR = '0;
   logic [7:0]    SNES_DATA = '0;
   logic          SNES_reset_strobe = 1'b0;
   logic          snescmd_wr_strobe = 1'b0;
   logic          SNES_cycle_start = 1'b0;
   logic [IW-1:0] pgm_idx = '0;
   logic          pgm_we = 1'b0;
   logic [31:0]   pgm_in = '0;
   logic [IW-1:0] rd_idx = '0;
   logic [HW-1:0] rd_data;
   logic [7:0]    data_out;
   logic          cheat_hit;

   cheat_engine_multi #(
      .NUM_SLOTS(NS), .HOLDOFF_CYCLES(100), .USAGE_WIN_LOG2(6), .SYNC_CYCLES(2), .HITW(HW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .SNES_ADDR(SNES_ADDR), .SNES_DATA(SNES_DATA),
      .SNES_reset_strobe(SNES_reset_strobe), .snescmd_wr_strobe(snescmd_wr_strobe),
      .SNES_cycle_start(SNES_cycle_start), .pgm_idx(pgm_idx), .pgm_we(pgm_we), .pgm_in(pgm_in),
      .rd_idx(rd_idx), .rd_data(rd_data), .data_out(data_out), .cheat_hit(cheat_hit)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0]   m_addr [NS];
   logic [7:0]    m_data [NS];
   int            m_cnt  [NS];
   logic [NS-1:0] m_mask;
   logic          m_cheat, m_nmi_en, m_irq_en, m_hold_en, m_mode_irq, m_hook_ok;
   logic [23:0]   pool [4] = '{24'h008000, 24'h00c000, 24'h018000, 24'h7f0000};

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int exp_slot(input logic [23:0] a);
      for (int i = 0; i < NS; i++)
         if (m_mask[i] && m_addr[i] == a) return i;
      return -1;
   endfunction

   function automatic logic [7:0] exp_data(input logic [23:0] a);
      int s;
      s = exp_slot(a);
      if (s >= 0) return m_data[s];
      if (a == 24'h00ffea) return 8'he0;
      if (a == 24'h00ffee) return 8'he6;
      return 8'h2b;
   endfunction

   function automatic logic exp_hit(input logic [23:0] a);
      logic nv, iv;
      nv = (a == 24'h00ffea) || (a == 24'h00ffeb);
      iv = (a == 24'h00ffee) || (a == 24'h00ffef);
      return (m_cheat && exp_slot(a) >= 0) ||
             (m_hook_ok && ((!m_mode_irq && m_nmi_en && nv) || (m_mode_irq && m_irq_en && iv)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [23:0] a, input logic start, input logic chk, input string tag);
      int s;
      SNES_ADDR        = a;
      SNES_cycle_start = start;
      #1;
      if (chk) begin
         check_val({tag, "_data"}, 32'(data_out), 32'(exp_data(a)));
         check_val({tag, "_hit"}, 32'(cheat_hit), 32'(exp_hit(a)));
      end
      if (start && m_cheat) begin
         s = exp_slot(a);
         if (s >= 0 && m_cnt[s] < 255) m_cnt[s]++;
      end
      tick();
      SNES_cycle_start = 1'b0;
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) access(24'h7e1234, 1'b1, 1'b0, "quiet");
   endtask

   task automatic pgm(input int idx, input logic [31:0] v);
      pgm_idx = IW'(idx);
      pgm_in  = v;
      pgm_we  = 1'b1;
      tick();
      pgm_we  = 1'b0;
   endtask

   task automatic pgm_slot(input int i, input logic [23:0] a, input logic [7:0] d);
      pgm(i, {a, d});
      m_addr[i] = a;
      m_data[i] = d;
      m_cnt[i]  = 0;
   endtask

   task automatic pgm_mask(input logic [NS-1:0] m);
      pgm(NS, 32'(m));
      m_mask = m;
   endtask

   task automatic pgm_ctl(input logic [7:0] v);
      logic [3:0] cur;
      pgm(NS + 1, 32'(v));
      cur = ({m_hold_en, m_irq_en, m_nmi_en, m_cheat} & ~v[7:4]) | v[3:0];
      {m_hold_en, m_irq_en, m_nmi_en, m_cheat} = cur;
   endtask

   task automatic cmd(input logic [8:0] a, input logic [7:0] d);
      SNES_ADDR         = {15'h0, a};
      SNES_DATA         = d;
      snescmd_wr_strobe = 1'b1;
      tick();
      snescmd_wr_strobe = 1'b0;
      if (a == 9'h000) begin
         case (d)
            8'h82: m_cheat = 1'b1;
            8'h83: m_cheat = 1'b0;
            8'h84: begin m_nmi_en = 1'b0; m_irq_en = 1'b0; end
            8'h86: for (int i = 0; i < NS; i++) m_cnt[i] = 0;
            default: ;
         endcase
      end
   endtask

   task automatic read_cnt(input int idx, input int exp, input string tag);
      rd_idx = IW'(idx);
      tick();
      check_val(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic vec_reads(input logic [23:0] a, input logic [23:0] b, input int iters);
      for (int k = 0; k < iters; k++) begin
         access(a, 1'b1, 1'b0, "vr");
         access(b, 1'b1, 1'b0, "vr");
         repeat (18) tick();
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin m_addr[i] = '0; m_data[i] = '0; m_cnt[i] = 0; end
      m_mask = '0; m_cheat = 0; m_nmi_en = 0; m_irq_en = 0; m_hold_en = 0;
      m_mode_irq = 0; m_hook_ok = 0;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_data", 32'(data_out), 32'h2b);
      check_val("rst_hit", 32'(cheat_hit), 32'h0);
      check_val("rst_rd", 32'(rd_data), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      read_cnt(0, 0, "rd_idx0");
      read_cnt(NS + 1, 0, "rd_oob");

      pgm_slot(3, 24'h008000, 8'h5a);
      pgm_mask(8'h08);
      cmd(9'h000, 8'h82);
      access(24'h008000, 1'b0, 1'b1, "slot3_on");
      check_val("slot3_byte", 32'(data_out), 32'h5a);
      cmd(9'h000, 8'h83);
      access(24'h008000, 1'b0, 1'b1, "slot3_off");

      pgm_slot(1, 24'h00c000, 8'h11);
      pgm_slot(4, 24'h00c000, 8'h44);
      pgm_mask(8'h12);
      cmd(9'h000, 8'h82);
      for (int i = 0; i < 5; i++) access(24'h00c000, 1'b1, 1'b1, "prio");
      check_val("prio_byte", 32'(data_out), 32'h11);
      read_cnt(1, 5, "cnt1_five");
      read_cnt(4, 0, "cnt4_zero");

      for (int i = 0; i < 260; i++) access(24'h00c000, 1'b1, 1'b0, "sat");
      read_cnt(1, 255, "cnt1_sat");
      for (int i = 0; i < 3; i++) access(24'h00c000, 1'b1, 1'b0, "sat");
      read_cnt(1, 255, "cnt1_hold");
      cmd(9'h000, 8'h86);
      read_cnt(1, 0, "cnt1_clear");

      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(9, 0))
            0: pgm_slot($urandom_range(NS - 1, 0), pool[$urandom_range(3, 0)], 8'($urandom));
            1: pgm_mask(NS'($urandom));
            2: cmd(9'h000, ($urandom_range(1, 0) != 0) ? 8'h82 : 8'h83);
            3: access(24'($urandom), 1'($urandom), 1'b1, "rnd_any");
            default: access(pool[$urandom_range(3, 0)], 1'($urandom), 1'b1, "rnd_pool");
         endcase
      end
      for (int i = 0; i < NS; i++) read_cnt(i, m_cnt[i], "rnd_cnt");

      pgm_ctl(8'h02);
      vec_reads(24'h00ffea, 24'h00ffeb, 10);
      quiet(4);
      m_hook_ok = 1; m_mode_irq = 0;
      access(24'h00ffea, 1'b0, 1'b1, "nmi_lo");
      access(24'h00ffeb, 1'b0, 1'b1, "nmi_hi");
      access(24'h00ffee, 1'b0, 1'b1, "nmi_irqvec");

      pgm_ctl(8'h04);
      vec_reads(24'h00ffee, 24'h00ffef, 10);
      quiet(4);
      m_mode_irq = 1;
      access(24'h00ffee, 1'b0, 1'b1, "irq_lo");
      access(24'h00ffef, 1'b0, 1'b1, "irq_hi");
      access(24'h00ffea, 1'b0, 1'b1, "irq_nmivec");

      vec_reads(24'h00ffea, 24'h00ffeb, 10);
      quiet(4);
      m_mode_irq = 0;
      access(24'h00ffea, 1'b0, 1'b1, "nmi2_lo");
      access(24'h00ffee, 1'b0, 1'b1, "nmi2_irqvec");

      cmd(9'h000, 8'h85);
      quiet(4);
      m_hook_ok = 0;
      access(24'h00ffea, 1'b0, 1'b1, "hold_early");
      repeat (40) tick();
      quiet(4);
      access(24'h00ffea, 1'b0, 1'b1, "hold_mid");
      repeat (60) tick();
      quiet(4);
      m_hook_ok = 1;
      access(24'h00ffea, 1'b0, 1'b1, "hold_done");

      cmd(9'h1fd, 8'h01);
      quiet(4);
      m_hook_ok = 0;
      access(24'h00ffea, 1'b0, 1'b1, "hdis_on");
      cmd(9'h1fd, 8'h00);
      quiet(4);
      m_hook_ok = 1;
      access(24'h00ffea, 1'b0, 1'b1, "hdis_off");

      pgm_ctl(8'h08);
      SNES_reset_strobe = 1'b1;
      tick();
      SNES_reset_strobe = 1'b0;
      quiet(4);
      m_hook_ok = 0;
      access(24'h00ffea, 1'b0, 1'b1, "rst_strobe_hold");

      cmd(9'h000, 8'h84);
      access(24'h00ffea, 1'b0, 1'b1, "cmd84");

      pgm_slot(0, 24'h00c000, 8'h99);
      pgm_mask(8'h01);
      cmd(9'h000, 8'h82);
      for (int i = 0; i < 4; i++) access(24'h00c000, 1'b1, 1'b0, "pre_rst");
      read_cnt(0, 4, "pre_rst_cnt");
      SNES_ADDR = 24'h00c000;
      #3;
      rst_n = 1'b0;
      #1;
      check_val("async_hit", 32'(cheat_hit), 32'h0);
      check_val("async_data", 32'(data_out), 32'h2b);
      check_val("async_rd", 32'(rd_data), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
